load_unit: RTL and testbench

- Sequential, parametrised load unit that replaces the purely combinational load writeback path.
- Accepts a load request from the execute stage and issues word-aligned read(s) on a single-outstanding memory port.
- Extracts, sign- or zero-extends the result and returns it to the writeback stage with a valid pulse.
- Supports XLEN 32/64, pipeline flush and an optional two-beat misaligned split.

---
 rtl/load_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_load_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit: sequential load unit with extension; optional LOAD_UNIT_MISALIGN_SPLIT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [RD_W-1:0] req_rd_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o,
  output logic [XLEN-1:0] err_addr_o
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(BYTES - 1);
  localparam logic [XLEN-1:0] BEAT_STEP  = XLEN'(BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5,
    ERR   = 3'd6,
    DRAIN = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            req_illegal;
  logic            req_dbl_bad;
  logic [2*XLEN-1:0] beats;
  logic [OFF_W+2:0]  shamt;
  logic [XLEN-1:0]   raw, mask, ext_data;
  logic [7:0]        nbits;
  logic [IDX_W-1:0]  top_idx;

  assign req_dbl_bad = (XLEN == 32) && (req_size_i == 2'b11);

`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] lo_q, lo_d;
  logic            need_split;

  assign req_illegal = req_dbl_bad;
  // A split is needed when the access runs past the end of the first beat.
  assign need_split  = (5'(addr_q[OFF_W-1:0]) + 5'(4'd1 << size_q)) > 5'(BYTES);
`else
  logic [3:0] req_bytes;
  logic [3:0] req_off;

  assign req_bytes   = 4'd1 << req_size_i;
  assign req_off     = 4'(req_addr_i[OFF_W-1:0]);
  assign req_illegal = req_dbl_bad || ((req_off & (req_bytes - 4'd1)) != 4'd0);
`endif

  always_comb begin
    shamt = {addr_q[OFF_W-1:0], 3'b000};
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    beats = (state_q == WAIT2) ? {mem_rdata_i, lo_q} : {{XLEN{1'b0}}, mem_rdata_i};
`else
    beats = {{XLEN{1'b0}}, mem_rdata_i};
`endif
    raw   = XLEN'(beats >> shamt);
    nbits = 8'd8 << size_q;
    if (nbits > 8'(XLEN)) begin
      nbits = 8'(XLEN);
    end
    mask     = {XLEN{1'b1}} >> (8'(XLEN) - nbits);
    top_idx  = IDX_W'(nbits - 8'd1);
    ext_data = (raw & mask) | ((!uns_q && raw[top_idx]) ? ~mask : '0);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    mem_addr_d = mem_addr_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    lo_d       = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          addr_d = req_addr_i;
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          rd_d   = req_rd_i;
          if (req_illegal) begin
            state_d = ERR;
          end else begin
            state_d    = REQ1;
            mem_addr_d = req_addr_i & ALIGN_MASK;
          end
        end
      end
      REQ1: begin
        if (mem_gnt_i) begin
          state_d = flush_i ? DRAIN : WAIT1;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT1: begin
        // A flush coinciding with the data beat has nothing left to drain.
        if (mem_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
          end else if (need_split) begin
            lo_d       = mem_rdata_i;
            mem_addr_d = mem_addr_q + BEAT_STEP;
            state_d    = REQ2;
`endif
          end else begin
            wb_data_d = ext_data;
            wb_rd_d   = rd_q;
            state_d   = RESP;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
      REQ2: begin
        if (mem_gnt_i) begin
          state_d = flush_i ? DRAIN : WAIT2;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT2: begin
        if (mem_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            wb_data_d = ext_data;
            wb_rd_d   = rd_q;
            state_d   = RESP;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
`endif
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
      lo_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      mem_addr_q <= mem_addr_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
      lo_q       <= lo_d;
`endif
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ1) || (state_q == REQ2);
  assign mem_addr_o  = mem_addr_q;
  // A flush arriving in the pulse cycle cancels the pulse itself.
  assign wb_valid_o  = (state_q == RESP) && !flush_i;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = (state_q == ERR) && !flush_i;
  assign err_addr_o  = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
// ---------------------------------------------------------------------------
// tb_load_unit: directed bench for load_unit, XLEN=32 and XLEN=64 instances. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_unit;

  typedef struct {
    logic        sel64;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [63:0] b0;
    logic [63:0] b1;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_nreq;
    logic [63:0] exp_a0;
    logic [63:0] exp_a1;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;

  logic        r32, mq32, wv32, er32;
  logic [31:0] ma32, wd32, ea32;
  logic [4:0]  wr32;
  logic        r64, mq64, wv64, er64;
  logic [63:0] ma64, wd64, ea64;
  logic [4:0]  wr64;

  logic        o_ready, o_mreq, o_wbv, o_err;
  logic [63:0] o_maddr, o_wbdata, o_eaddr;
  logic [4:0]  o_wbrd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_unit #(.XLEN(32), .RD_W(5)) u_dut32 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & ~sel64), .req_ready_o(r32),
    .req_addr_i(req_addr[31:0]), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_rd_i(req_rd),
    .flush_i(flush & ~sel64),
    .mem_req_o(mq32), .mem_addr_o(ma32),
    .mem_gnt_i(gnt & ~sel64), .mem_rvalid_i(rvalid & ~sel64),
    .mem_rdata_i(rdata[31:0]),
    .wb_valid_o(wv32), .wb_rd_o(wr32), .wb_data_o(wd32),
    .err_o(er32), .err_addr_o(ea32)
  );

  load_unit #(.XLEN(64), .RD_W(5)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & sel64), .req_ready_o(r64),
    .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_rd_i(req_rd),
    .flush_i(flush & sel64),
    .mem_req_o(mq64), .mem_addr_o(ma64),
    .mem_gnt_i(gnt & sel64), .mem_rvalid_i(rvalid & sel64),
    .mem_rdata_i(rdata),
    .wb_valid_o(wv64), .wb_rd_o(wr64), .wb_data_o(wd64),
    .err_o(er64), .err_addr_o(ea64)
  );

  always_comb begin
    o_ready  = sel64 ? r64  : r32;
    o_mreq   = sel64 ? mq64 : mq32;
    o_maddr  = sel64 ? ma64 : {32'h0, ma32};
    o_wbv    = sel64 ? wv64 : wv32;
    o_wbrd   = sel64 ? wr64 : wr32;
    o_wbdata = sel64 ? wd64 : {32'h0, wd32};
    o_err    = sel64 ? er64 : er32;
    o_eaddr  = sel64 ? ea64 : {32'h0, ea32};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s64, input logic [63:0] addr, input logic [1:0] size,
                              input logic uns, input logic [4:0] rd, input logic [63:0] b0,
                              input logic [63:0] b1, input logic e, input logic [63:0] d,
                              input int nreq, input logic [63:0] a0, input logic [63:0] a1,
                              input int lat);
    vec_t v;
    v.sel64 = s64; v.addr = addr; v.size = size; v.uns = uns; v.rd = rd;
    v.b0 = b0; v.b1 = b1; v.exp_err = e; v.exp_data = d; v.exp_nreq = nreq;
    v.exp_a0 = a0; v.exp_a1 = a1; v.exp_lat = lat;
    return v;
  endfunction

  // Issues one request and plays a zero-wait memory: grant at first sight, data the next cycle.
  task automatic apply(input vec_t v, input string tag);
    logic        got_wb, got_err, gave_gnt, ready_after;
    logic [63:0] data, eaddr, a0, a1;
    logic [4:0]  rd;
    int          nreq, lat;
    sel64 = v.sel64; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_rd = v.rd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    gave_gnt = 1'b0; got_wb = 1'b0; got_err = 1'b0; nreq = 0; lat = 0;
    data = '0; eaddr = '0; a0 = '0; a1 = '0; rd = '0;
    for (int cyc = 1; cyc <= 12 && lat == 0; cyc++) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (o_wbv) begin
        got_wb = 1'b1; data = o_wbdata; rd = o_wbrd; lat = cyc;
      end else if (o_err) begin
        got_err = 1'b1; eaddr = o_eaddr; lat = cyc;
      end else if (gave_gnt) begin
        rvalid = 1'b1; rdata = (nreq == 1) ? v.b0 : v.b1; gave_gnt = 1'b0;
      end else if (o_mreq) begin
        nreq++;
        if (nreq == 1) a0 = o_maddr; else a1 = o_maddr;
        gnt = 1'b1; gave_gnt = 1'b1;
      end
      @(negedge clk);
    end
    gnt = 1'b0; rvalid = 1'b0;
    ready_after = o_ready;
    check({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_err"}, {63'h0, got_err}, {63'h0, v.exp_err});
    check({tag, "_wb"}, {63'h0, got_wb}, {63'h0, ~v.exp_err});
    check({tag, "_nreq"}, 64'(nreq), 64'(v.exp_nreq));
    check({tag, "_ready_after"}, {63'h0, ready_after}, 64'h1);
    if (v.exp_err) begin
      check({tag, "_err_addr"}, eaddr, v.addr);
    end else begin
      check({tag, "_data"}, data, v.exp_data);
      check({tag, "_rd"}, {59'h0, rd}, {59'h0, v.rd});
      check({tag, "_addr0"}, a0, v.exp_a0);
      if (v.exp_nreq == 2) check({tag, "_addr1"}, a1, v.exp_a1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk(0, 64'h1003, 2'b00, 0, 5'd1, 64'h80112233, 0, 0, 64'hFFFFFF80, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h1003, 2'b00, 1, 5'd2, 64'h80112233, 0, 0, 64'h00000080, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h1002, 2'b01, 0, 5'd3, 64'h80112233, 0, 0, 64'hFFFF8011, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h1002, 2'b01, 1, 5'd4, 64'h80112233, 0, 0, 64'h00008011, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h1001, 2'b00, 0, 5'd5, 64'h80112233, 0, 0, 64'h00000022, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h2000, 2'b10, 0, 5'd6, 64'h12345678, 0, 0, 64'h12345678, 1, 64'h2000, 0, 3));
    vecs.push_back(mk(0, 64'h1000, 2'b11, 0, 5'd7, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 64'h2004, 2'b10, 0, 5'd8, 64'h8765432100000000, 0, 0, 64'hFFFFFFFF87654321, 1, 64'h2000, 0, 3));
    vecs.push_back(mk(1, 64'h2004, 2'b10, 1, 5'd9, 64'h8765432100000000, 0, 0, 64'h0000000087654321, 1, 64'h2000, 0, 3));
    vecs.push_back(mk(1, 64'h3008, 2'b11, 0, 5'd10, 64'hFEDCBA9876543210, 0, 0, 64'hFEDCBA9876543210, 1, 64'h3008, 0, 3));
    vecs.push_back(mk(1, 64'h3007, 2'b00, 0, 5'd11, 64'h7F11223344556677, 0, 0, 64'h7F, 1, 64'h3000, 0, 3));
    vecs.push_back(mk(1, 64'h3006, 2'b01, 0, 5'd12, 64'h8001000000000000, 0, 0, 64'hFFFFFFFFFFFF8001, 1, 64'h3000, 0, 3));
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    vecs.push_back(mk(0, 64'h1001, 2'b01, 0, 5'd13, 64'h80112233, 0, 0, 64'h1122, 1, 64'h1000, 0, 3));
    vecs.push_back(mk(0, 64'h0FFE, 2'b10, 0, 5'd14, 64'hAABB0000, 64'h0000CCDD, 0, 64'hCCDDAABB, 2, 64'h0FFC, 64'h1000, 5));
    vecs.push_back(mk(0, 64'hFFFFFFFE, 2'b10, 0, 5'd15, 64'hAABB0000, 64'h0000CCDD, 0, 64'hCCDDAABB, 2, 64'hFFFFFFFC, 64'h0, 5));
    vecs.push_back(mk(1, 64'h2006, 2'b10, 0, 5'd16, 64'h2211000000000000, 64'h8433, 0, 64'hFFFFFFFF84332211, 2, 64'h2000, 64'h2008, 5));
`else
    vecs.push_back(mk(0, 64'h1002, 2'b10, 0, 5'd13, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 64'h1001, 2'b01, 1, 5'd14, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 64'h2006, 2'b10, 0, 5'd15, 0, 0, 1, 0, 0, 0, 0, 1));
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready32", {63'h0, r32}, 64'h1);
    check("rst_ready64", {63'h0, r64}, 64'h1);
    check("rst_outs32", {59'h0, mq32, wv32, er32, 2'b00}, 64'h0);
    check("rst_outs64", {59'h0, mq64, wv64, er64, 2'b00}, 64'h0);
    check("rst_data32", {wd32, ea32}, 64'h0);
    check("rst_data64", wd64 | ea64 | ma64, 64'h0);
    check("rst_misc32", {27'h0, ma32, wr32}, 64'h0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Stalled grant, then a flush while waiting for data.
    sel64 = 1'b0; req_addr = 64'h4000; req_size = 2'b10; req_unsigned = 1'b0;
    req_rd = 5'd20; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_req", k), {63'h0, o_mreq}, 64'h1);
      check($sformatf("stall%0d_addr", k), o_maddr, 64'h4000);
      @(negedge clk);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("wait1_req_low", {63'h0, o_mreq}, 64'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("drain_not_ready", {63'h0, o_ready}, 64'h0);
    @(negedge clk);
    check("drain_no_wb_a", {63'h0, o_wbv}, 64'h0);
    @(negedge clk);
    rvalid = 1'b1; rdata = 64'hDEADBEEF;
    @(negedge clk);
    rvalid = 1'b0;
    check("drain_ready_back", {63'h0, o_ready}, 64'h1);
    check("drain_no_wb_b", {63'h0, o_wbv}, 64'h0);

    req_addr = 64'h6000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("req1_flush_pre", {63'h0, o_mreq}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("req1_flush_req", {63'h0, o_mreq}, 64'h0);
    check("req1_flush_ready", {63'h0, o_ready}, 64'h1);

    // Reset while waiting for data, then a stray late response.
    req_addr = 64'h5001; req_size = 2'b00; req_rd = 5'd21; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", {63'h0, r32}, 64'h1);
    check("rst_mid_ctl", {61'h0, mq32, wv32, er32}, 64'h0);
    check("rst_mid_addr", {32'h0, ma32}, 64'h0);
    check("rst_mid_wb", {27'h0, wd32, wr32}, 64'h0);
    check("rst_mid_eaddr", {32'h0, ea32}, 64'h0);
    rvalid = 1'b1; rdata = 64'h0000FFFF;
    @(negedge clk);
    rvalid = 1'b0;
    check("stray_no_wb", {63'h0, o_wbv}, 64'h0);
    check("stray_ready", {63'h0, o_ready}, 64'h1);
    @(negedge clk);
    check("stray_no_wb2", {63'h0, o_wbv}, 64'h0);
    apply(mk(0, 64'h5001, 2'b00, 0, 5'd22, 64'h0000A500, 0, 0, 64'hFFFFFFA5, 1, 64'h5000, 0, 3), "post_rst_lb");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
